// File: rtl/mem_sweep_pkg.sv
// Shared types and default widths for the mem_sweep write/readback sequencer
// and the e6s4 memory wrapper.
package mem_sweep_pkg;

    localparam int unsigned MEM_ADDR_W = 2;
    localparam int unsigned MEM_DATA_W = 2;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        RD_ADDR = 2'd1,
        RD_CAP  = 2'd2,
        RD_OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_sweep_if.sv
// Bundle of the upstream bit stream, memory pins and downstream readback
// handshake for mem_sweep_ctrl. Optional macro: MEM_SWEEP_PARITY_EN adds
// out_parity.
interface mem_sweep_if
    import mem_sweep_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
);
    logic              in_valid;
    logic              in_bit;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_din;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_dout;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_ready;
    logic              busy;
`ifdef MEM_SWEEP_PARITY_EN
    logic              out_parity;
`endif

    // Sequencer side
    modport slave (
        input  in_valid, in_bit, mem_dout, out_ready,
        output in_ready, mem_address, mem_din, mem_wr,
        output out_valid, out_data, out_addr, busy
`ifdef MEM_SWEEP_PARITY_EN
        , output out_parity
`endif
    );

    // Environment side: bit source, memory and readback sink
    modport master (
        output in_valid, in_bit, mem_dout, out_ready,
        input  in_ready, mem_address, mem_din, mem_wr,
        input  out_valid, out_data, out_addr, busy
`ifdef MEM_SWEEP_PARITY_EN
        , input out_parity
`endif
    );

endinterface

// File: rtl/mem_sweep_ctrl.sv
// Write/readback sequencer for the bit-addressed e6s4 memory: fills every
// address from a serial bit stream, then sweeps all addresses and returns
// each Dout word over a valid/ready handshake.
// Optional macro: MEM_SWEEP_PARITY_EN adds an even-parity bit on readback.
module mem_sweep_ctrl
    import mem_sweep_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input logic       clk,
    input logic       rst,
    mem_sweep_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] mem_address_q;
    logic              mem_din_q;
    logic              mem_wr_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [ADDR_W-1:0] out_addr_q;
`ifdef MEM_SWEEP_PARITY_EN
    logic              out_parity_q;
`endif

    // Sequencer FSM with registered memory pins and readback registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FILL;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            mem_address_q <= '0;
            mem_din_q     <= 1'b0;
            mem_wr_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_addr_q    <= '0;
`ifdef MEM_SWEEP_PARITY_EN
            out_parity_q  <= 1'b0;
`endif
        end else begin
            case (state)
                FILL: begin
                    mem_wr_q <= 1'b0;
                    if (bus.in_valid) begin
                        mem_address_q <= wr_ptr;
                        mem_din_q     <= bus.in_bit;
                        mem_wr_q      <= 1'b1;
                        if (wr_ptr == LAST) begin
                            wr_ptr <= '0;
                            state  <= RD_ADDR;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    // Entered straight from FILL the final write is still on
                    // the pins, so spend one extra cycle presenting the read
                    // address; from RD_OUT the address was set on entry.
                    mem_address_q <= rd_ptr;
                    mem_wr_q      <= 1'b0;
                    if (!mem_wr_q) begin
                        state <= RD_CAP;
                    end
                end
                RD_CAP: begin
                    out_data_q   <= bus.mem_dout;
                    out_addr_q   <= rd_ptr;
                    out_valid_q  <= 1'b1;
`ifdef MEM_SWEEP_PARITY_EN
                    out_parity_q <= ^bus.mem_dout;
`endif
                    state        <= RD_OUT;
                end
                RD_OUT: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        mem_wr_q    <= 1'b0;
                        if (rd_ptr == LAST) begin
                            rd_ptr <= '0;
                            state  <= FILL;
                        end else begin
                            rd_ptr        <= rd_ptr + 1'b1;
                            mem_address_q <= rd_ptr + 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.in_ready    = (state == FILL);
    assign bus.busy        = (state != FILL);
    assign bus.mem_address = mem_address_q;
    assign bus.mem_din     = mem_din_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_addr    = out_addr_q;
`ifdef MEM_SWEEP_PARITY_EN
    assign bus.out_parity  = out_parity_q;
`endif

endmodule
